// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage issue logic and muldiv_unit.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic            flush;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            we;
   logic            illegal;

   modport master (
      output start, flush, op, a, b, rd_in,
      input  busy, done, result, rd_out, we, illegal
   );

   modport slave (
      input  start, flush, op, a, b, rd_in,
      output busy, done, result, rd_out, we, illegal
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply, 32-step restoring divide.
// Divider datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_unit_if.slave bus
);
   localparam int unsigned     PW        = 2 * XLEN;
   localparam int unsigned     CNT_W     = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [2:0]      OP_MULH   = 3'b001;
   localparam logic [2:0]      OP_MULHSU = 3'b010;
   localparam logic [2:0]      OP_DIV    = 3'b100;
   localparam logic [2:0]      OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   b_q;
   logic [PW-1:0]     acc_q, acc_nxt, prod_s;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN:0]     mul_sum;
   logic              accept, special, spec_ill, a_sgn, b_sgn, neg_in;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res, fix_res, res_d;
   logic [4:0]        rd_d;
   logic              busy_d, done_d, we_d, ill_d;
`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0]   rem_q, rem_nxt, rem_sub;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
`endif

   always_comb begin
      accept = bus.start && !bus.flush && ((state_q == IDLE) || (state_q == DONE));
   end

   // Operand sign decode, magnitudes and special-case detection at acceptance.
   always_comb begin
      a_sgn    = 1'b0;
      b_sgn    = 1'b0;
      special  = 1'b0;
      spec_ill = 1'b0;
      spec_res = '0;
      case (bus.op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         OP_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
      a_mag  = (a_sgn && bus.a[XLEN-1]) ? (~bus.a + XLEN'(1)) : bus.a;
      b_mag  = (b_sgn && bus.b[XLEN-1]) ? (~bus.b + XLEN'(1)) : bus.b;
      // remainder follows the dividend only; quotient/product follow both signs
      neg_in = (a_sgn && bus.a[XLEN-1]) ^ (b_sgn && bus.b[XLEN-1] && (bus.op != OP_REM));
`ifdef MULDIV_DIV_EN
      if (bus.op[2]) begin
         if (bus.b == '0) begin
            special  = 1'b1;
            spec_res = bus.op[1] ? bus.a : '1;
         end else if (!bus.op[0] && (bus.a == SMIN) && (bus.b == '1)) begin
            special  = 1'b1;
            spec_res = bus.op[1] ? '0 : SMIN;
         end
      end
`else
      if (bus.op[2]) begin
         special  = 1'b1;
         spec_ill = 1'b1;
      end
`endif
   end

   // One iteration step and final sign correction.
   always_comb begin
      mul_sum = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, b_q};
      acc_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[PW-1:1]};
      prod_s  = neg_q ? (~acc_q + PW'(1)) : acc_q;
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
`ifdef MULDIV_DIV_EN
      rem_sh  = {rem_q, acc_q[XLEN-1]};
      rem_ge  = (rem_sh >= {1'b0, b_q});
      rem_sub = rem_sh[XLEN-1:0] - b_q;
      rem_nxt = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
      if (op_q[2]) begin
         acc_nxt = {{XLEN{1'b0}}, acc_q[XLEN-2:0], rem_ge};
         if (op_q[1]) fix_res = neg_q ? (~rem_q + XLEN'(1)) : rem_q;
         else         fix_res = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
      end
`else
      if (op_q[2]) fix_res = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = accept ? (special ? DONE : CALC) : IDLE;
         CALC:       if (cnt_q == '0) state_d = FIX;
         FIX:        state_d = DONE;
         default:    state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   // Outputs are computed from the next state and registered.
   always_comb begin
      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
      res_d  = bus.result;
      rd_d   = bus.rd_out;
      ill_d  = 1'b0;
      if (done_d) begin
         if (state_q == FIX) begin
            res_d = fix_res;
            rd_d  = rd_q;
         end else begin
            res_d = spec_res;
            rd_d  = bus.rd_in;
            ill_d = spec_ill;
         end
      end
      we_d = done_d && (rd_d != '0) && !ill_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         rd_q        <= '0;
         neg_q       <= 1'b0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
`ifdef MULDIV_DIV_EN
         rem_q       <= '0;
`endif
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.we      <= 1'b0;
         bus.illegal <= 1'b0;
         bus.result  <= '0;
         bus.rd_out  <= '0;
      end else begin
         if (accept) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd_in;
            neg_q <= neg_in;
            b_q   <= b_mag;
            acc_q <= {{XLEN{1'b0}}, a_mag};
            cnt_q <= CNT_W'(XLEN - 1);
`ifdef MULDIV_DIV_EN
            rem_q <= '0;
`endif
         end else if (state_q == CALC) begin
            acc_q <= acc_nxt;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
`ifdef MULDIV_DIV_EN
            rem_q <= rem_nxt;
`endif
         end
         bus.busy    <= busy_d;
         bus.done    <= done_d;
         bus.we      <= we_d;
         bus.illegal <= ill_d;
         bus.result  <= res_d;
         bus.rd_out  <= rd_d;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      int          issue;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic ill, input int lat);
      exp_t e;
      e.res   = res;
      e.rd    = rd;
      e.ill   = ill;
      e.we    = (rd != 5'd0) && !ill;
      e.issue = cyc;
      e.lat   = lat;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.rd_in = rd;
   endtask

   // Caller sits at a negedge; the op is accepted at the following posedge.
   task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit exp_on, input logic [31:0] res,
                            input int lat);
      drive(op, a, b, rd);
      if (exp_on) push(res, rd, 1'b0, lat);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit exp_on, input logic [31:0] res,
                        input int lat);
      @(negedge clk);
      issue_now(op, a, b, rd, exp_on, res, lat);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!bus.done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Divide ops trap as illegal with single-cycle done when the divider is absent.
   task automatic div_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input string name);
      @(negedge clk);
      drive(op, a, b, rd);
      if (DIV_EN) push(res, rd, 1'b0, lat);
      else        push(32'd0, rd, 1'b1, 1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(name);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("result_rd%0d", mon_e.rd), bus.result, mon_e.res);
            chk($sformatf("rd_out_rd%0d", mon_e.rd), 32'(bus.rd_out), 32'(mon_e.rd));
            chk($sformatf("we_rd%0d", mon_e.rd), 32'(bus.we), 32'(mon_e.we));
            chk($sformatf("illegal_rd%0d", mon_e.rd), 32'(bus.illegal), 32'(mon_e.ill));
            chk($sformatf("latency_rd%0d", mon_e.rd), 32'(cyc - mon_e.issue), 32'(mon_e.lat));
         end
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 3'd0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      bus.rd_in = 5'd0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd_out", 32'(bus.rd_out), 32'd0);
      rst_n = 1'b1;

      // MUL with busy profile over cycles 1..34
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, 34);
      for (int k = 1; k <= 33; k++) begin
         chk($sformatf("mul_busy_c%0d", k), 32'(bus.busy), 32'd1);
         @(negedge clk);
      end
      chk("mul_busy_c34", 32'(bus.busy), 32'd0);
      wait_done("mul");

      div_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34, "div");
      div_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34, "rem");
      div_op(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 34, "divu");
      div_op(3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 34, "remu");
      div_op(3'b100, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1, "div_by0");
      div_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1, "rem_ovf");
      div_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, "div_ovf");
      div_op(3'b111, 32'd9, 32'd0, 5'd8, 32'd9, 1, "remu_by0");

      // back-to-back chain: each start lands in the previous done cycle
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1, 32'h4000_0000, 34);
      wait_done("mulh");
      issue_now(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1, 32'hFFFF_FFFF, 34);
      wait_done("mulhsu");
      issue_now(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'hFFFF_FFFE, 34);
      wait_done("mulhu");

      // flush in cycle 10 of a MUL
      issue(3'b000, 32'd123, 32'd456, 5'd15, 1'b0, 32'd0, 0);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_busy_c11", 32'(bus.busy), 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_result_held", bus.result, 32'hFFFF_FFFE);
      chk("flush_rd_out_held", 32'(bus.rd_out), 32'd9);

      issue(3'b000, 32'd3, 32'd5, 5'd10, 1'b1, 32'd15, 34);
      wait_done("mul_after_flush");

      // flush and start together: start dropped
      @(negedge clk);
      drive(3'b000, 32'd5, 32'd5, 5'd12);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("flush_start_busy", 32'(bus.busy), 32'd0);
      repeat (5) @(negedge clk);
      chk("flush_start_result", bus.result, 32'd15);

      issue(3'b000, 32'd6, 32'd7, 5'd0, 1'b1, 32'd42, 34);
      wait_done("rd0");

      // start held high while busy; later operands must be ignored
      @(negedge clk);
      drive(3'b000, 32'd2, 32'd3, 5'd11);
      push(32'd6, 5'd11, 1'b0, 34);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.a = 32'(k + 100);
         bus.b = 32'(k);
      end
      bus.start = 1'b0;
      wait_done("held_start");

      // async reset mid-CALC
      issue(3'b000, 32'd9, 32'd9, 5'd13, 1'b0, 32'd0, 0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_we", 32'(bus.we), 32'd0);
      chk("arst_illegal", 32'(bus.illegal), 32'd0);
      chk("arst_result", bus.result, 32'd0);
      chk("arst_rd_out", 32'(bus.rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_idle_busy", 32'(bus.busy), 32'd0);

      issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd14, 1'b1, 32'd1, 34);
      wait_done("mulhu_after_rst");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, fed directly by the register file's two read ports (RD1 → `a`, RD2 → `b`). It produces a 32-bit result plus a write request that drives the register file write port (WD3/A3/WE3). Each operation completes in a fixed number of cycles, and the unit holds the pipeline busy while it runs. Multiply uses a 32-step shift-add; divide uses a 32-step restoring algorithm.

## Interface
- `XLEN`, 32: operand/result width; only 32 supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `flush` in 1: synchronous abort of any in-flight op.
- `op` in 3: RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` in 32: rs1 operand (from RD1).
- `b` in 32: rs2 operand (from RD2).
- `rd_in` in 5: destination register index.
- `busy` out 1: op in progress; upstream must stall.
- `done` out 1: one-cycle pulse; `result`/`rd_out` valid.
- `result` out 32: held until next accepted op.
- `rd_out` out 5: latched `rd_in`.
- `we` out 1: `done && rd_out != 0`; drives WE3.
- `illegal` out 1: valid with `done`; see Configuration.

## Operation
- States: IDLE, CALC, FIX, DONE. `busy` = (CALC or FIX).
- IDLE/DONE + `start`:
  - Latch `op`, `a`, `b`, `rd_in`; counter = 31.
  - Normal op → CALC.
  - Special-case op → DONE directly.
- CALC: one multiply or divide step per cycle; counter decrements; after the step at counter 0 → FIX.
- FIX: apply sign correction, register `result` → DONE.
- DONE: `done`=1 for exactly one cycle; → IDLE unless `start` (back-to-back accepted).
- Signed handling:
  - Operands are converted to magnitudes before CALC.
  - MULH: both operands signed. MULHSU: `a` signed, `b` unsigned.
  - Product negated if signs differ.
  - Quotient negated if signs differ; remainder takes the sign of the dividend.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - Internal product is 64 bits; divide datapath is 33-bit remainder plus 32-bit quotient.
- Special cases (no CALC):
  - `b`=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `a`.
  - DIV with `a`=0x80000000, `b`=0xFFFFFFFF → 0x80000000; REM → 0.
- `flush`:
  - Any state → IDLE next edge, no `done`.
  - `result` and `rd_out` are not updated.
  - `flush` and `start` in the same cycle: flush wins, start dropped.
- Reset: state IDLE; `busy`, `done`, `we`, `illegal` = 0; `result` = 0; `rd_out` = 0; counter = 0.
- Reset asserted mid-op: op is lost and no `done` is produced.

## Timing
- `start` accepted in cycle 0 (edge E0).
- Normal op: `busy` high cycles 1–33, `done` high in cycle 34.
- Special case: `done` high in cycle 1, `busy` never asserts.
- Back-to-back: `start` in the `done` cycle is accepted, giving a new `done` 34 cycles later.
- `start` while `busy`=1 is ignored.
- Inputs other than `start`/`flush` are don't-care after acceptance.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath compiled in; DIV/DIVU/REM/REMU behave as above.
  - `illegal` is always 0.
- Undefined:
  - Divider logic removed; multiply behaviour unchanged.
  - Any op with `op[2]`=1 goes straight to DONE: `done` in cycle 1, `result`=0, `illegal`=1, `we`=0.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD, `rd_in`=5 → cycle 34: `done`=1, `result`=0xFFFFFFEB, `rd_out`=5, `we`=1; `busy` high cycles 1–33.
- MULH `a`=`b`=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with `done` in cycle 34.
- DIV `b`=0 → 0xFFFFFFFF, `done` cycle 1. REM 0x80000000/0xFFFFFFFF → 0, `done` cycle 1. REMU 9/0 → 9.
- Flush and start scenarios:
  - `flush` in cycle 10 of a MUL → `busy`=0 in cycle 11, no `done`, `result` unchanged.
  - Next `start` gives a correct result.
  - `start` with `rd_in`=0 → `done`=1, `we`=0.
  - `start` held during `busy` → ignored.
- Reset and configuration:
  - `rst_n` low mid-CALC → all outputs 0 immediately (async); no `done` after release.
  - With `MULDIV_DIV_EN` undefined: DIVU 100/7 → cycle 1 `done`=1, `result`=0, `illegal`=1, `we`=0.
